// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state encoding and constants for the serial pattern detector
package seqdet_pkg;

  localparam int SEQDET_MAX_LEN_LIMIT = 32;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_FILLING  = 2'd1,
    ST_ARMED    = 2'd2
  } seqdet_state_e;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seqdet_hist.sv
// rtl/seqdet_hist.sv - history shift register, saturating fill counter and length-masked comparator
module seqdet_hist
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               din_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic [LEN_W-1:0]   fill_next_o,
  output logic               match_next_o
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic               hit;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_i);
    end

    hist_d   = hist_q;
    fill_d   = fill_q;
    hit      = 1'b0;
    fill_inc = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);

    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], din_i};
      fill_d = fill_inc;
      hit    = (len_i != '0) && (fill_inc >= len_i) &&
               (((hist_d ^ pattern_i) & len_mask) == '0);
      // Non-overlapping mode restarts the count so the next match needs len fresh bits.
      if (hit && (overlap_i == OVL_OFF)) begin
        fill_d = '0;
      end
    end
  end

  assign match_next_o = hit;
  assign fill_next_o  = fill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - programmable serial pattern detector; SEQDET_CNT_EN adds a saturating match counter
module seq_detect_param
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_vld,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               dout,
  output logic               cfg_err
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  if (MAX_LEN < 2 || MAX_LEN > SEQDET_MAX_LEN_LIMIT || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: unsupported MAX_LEN or CNT_W");
  end

  seqdet_state_e      state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               dout_q;
  logic               cfg_err_q;

  logic               cfg_legal;
  logic               shift;
  logic               match_next;
  logic [LEN_W-1:0]   fill_next;

  assign cfg_legal = cfg_we && len_legal(32'(cfg_len), MAX_LEN);
  // A config write wins over a data bit in the same cycle.
  assign shift     = din_vld && !cfg_we;

  seqdet_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cfg_legal),
    .shift_i      (shift),
    .din_i        (din),
    .pattern_i    (pattern_q),
    .len_i        (len_q),
    .overlap_i    (overlap_q),
    .fill_next_o  (fill_next),
    .match_next_o (match_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DISARMED;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= OVL_ON;
      dout_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      dout_q <= match_next;
      if (cfg_we) begin
        if (cfg_legal) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
          state_q   <= ST_FILLING;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else if (shift) begin
        case (state_q)
          ST_FILLING: if (fill_next >= len_q) state_q <= ST_ARMED;
          ST_ARMED:   if (match_next && (overlap_q == OVL_OFF)) state_q <= ST_FILLING;
          default:    state_q <= state_q;
        endcase
      end
    end
  end

  assign dout    = dout_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cfg_legal) begin
      cnt_q <= '0;
    end else if (match_next && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param; SEQDET_CNT_EN adds counter checks
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               din;
  logic               din_vld;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               dout;
  logic               cfg_err;
`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int seg_hits = 0;
  logic exp_q[$];

  logic [7:0] m_pat, m_hist;
  int         m_len, m_fill, m_cnt;
  logic       m_ovl, m_err;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_vld     (din_vld),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .dout        (dout),
    .cfg_err     (cfg_err)
`ifdef SEQDET_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic d, input logic v, input logic we, input logic [7:0] pat,
                            input int len, input logic ovl, output logic e);
    e = 1'b0;
    if (we) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_hist = '0; m_fill = 0; m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (v) begin
      m_hist = {m_hist[6:0], d};
      if (m_fill < MAX_LEN) m_fill++;
      if (m_len != 0 && m_fill >= m_len) begin
        e = 1'b1;
        for (int i = 0; i < m_len; i++) if (m_hist[i] != m_pat[i]) e = 1'b0;
      end
      if (e && !m_ovl) m_fill = 0;
      if (e && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  task automatic cyc(input logic d, input logic v, input logic we, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl);
    logic e;
    @(negedge clk);
    din = d; din_vld = v; cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    model_step(d, v, we, pat, int'(len), ovl, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("dout", dout, exp_q.pop_front());
    seg_hits += int'(dout);
    chk("cfg_err", cfg_err, m_err);
`ifdef SEQDET_CNT_EN
    chk("match_cnt", match_cnt, m_cnt);
`endif
    din_vld = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic bit_in(input logic d);
    cyc(d, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic gap();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cyc(1'b0, 1'b0, 1'b1, pat, len, ovl);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b0; cfg_we = 1'b0;
    m_pat = '0; m_len = 0; m_ovl = 1'b1; m_hist = '0; m_fill = 0; m_err = 1'b0; m_cnt = 0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_cfg_err", cfg_err, 0);
`ifdef SEQDET_CNT_EN
    chk("rst_match_cnt", match_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cnt_exp [5];
    rst_n = 1'b1; din = 1'b0; din_vld = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    do_reset();

    // disarmed detector never fires
    seg_hits = 0; feed(32'b1101, 4);
    chk("disarmed_hits", seg_hits, 0);

    cfg(8'b1101, 4'd4, 1'b1);
    seg_hits = 0; feed(32'b1101101, 7);
    chk("ovl_hits", seg_hits, 2);

    cfg(8'b1101, 4'd4, 1'b0);
    seg_hits = 0; feed(32'b1101101, 7);
    chk("novl_hits", seg_hits, 1);

    cfg(8'b1101, 4'd4, 1'b1);
    seg_hits = 0; feed(32'b110, 3);
    do_reset();
    bit_in(1'b1);
    chk("rst_mid_hits", seg_hits, 0);

    cfg(8'b1101, 4'd4, 1'b1);
    seg_hits = 0;
    bit_in(1'b1); gap(); bit_in(1'b1); bit_in(1'b0); gap(); bit_in(1'b1);
    chk("gap_hits", seg_hits, 1);

    cfg(8'h00, 4'd0, 1'b0);
    chk("err_len0", cfg_err, 1);
    seg_hits = 0; feed(32'b1101, 4);
    chk("err_keep_cfg_hits", seg_hits, 1);
    cfg(8'h00, 4'd9, 1'b0);
    chk("err_sticky", cfg_err, 1);

    seg_hits = 0;
    cyc(1'b1, 1'b1, 1'b1, 8'b11, 4'd2, 1'b1);
    bit_in(1'b1);
    chk("we_drop_bit_hits", seg_hits, 0);
    bit_in(1'b1);
    chk("we_drop_then_hit", seg_hits, 1);

    cfg(8'b1, 4'd1, 1'b1);
    seg_hits = 0; feed(32'b1011, 4);
    chk("len1_hits", seg_hits, 3);

    cfg(8'hA5, 4'd8, 1'b1);
    seg_hits = 0; feed(32'hA5, 8);
    chk("len8_hits", seg_hits, 1);
    seg_hits = 0; feed(32'h3C5A5A5, 28);
    chk("len8_sat_hits", seg_hits, 2);

    for (int r = 0; r < 4; r++) begin
      cfg(8'($urandom), 4'($urandom_range(1, MAX_LEN)), 1'($urandom));
      for (int k = 0; k < 40; k++) cyc(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 8'h00, 4'd0, 1'b0);
    end

`ifdef SEQDET_CNT_EN
    cnt_exp = '{1, 2, 3, 3, 3};
    cfg(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      chk("cnt_seq", match_cnt, cnt_exp[i]);
    end
    cfg(8'b1, 4'd1, 1'b1);
    chk("cnt_clear_on_cfg", match_cnt, 0);
`else
    cnt_exp = '{0, 0, 0, 0, 0};
`endif

    chk("scoreboard_drained", exp_q.size(), cnt_exp[0] * 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. Generalises the team's fixed 4-bit Moore detectors.
- Pattern and length are loaded through a config port.
- Overlapping or non-overlapping match mode is selectable.
- Input is qualified by a valid strobe.
- Sits between a serial deserialiser front-end and control logic, which consumes a registered one-cycle match pulse.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 2..32)
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived; do not override)
CNT_W, 8, width of match counter (only used with SEQDET_CNT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
din  in  1  serial data bit
din_vld  in  1  din qualifier; bit consumed only when high
cfg_we  in  1  config write strobe
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the oldest bit, bit [0] the newest
cfg_len  in  LEN_W  pattern length in bits
cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
dout  out  1  registered match pulse (Moore)
cfg_err  out  1  sticky: an illegal config write was rejected
match_cnt  out  CNT_W  saturating match count (SEQDET_CNT_EN only)

Behaviour:
- Reset (rst_n low, async). Clears:
  - pattern = 0, len = 0 (detector disarmed), overlap = 1
  - hist = 0, fill = 0
  - dout = 0, cfg_err = 0, match_cnt = 0
- Config, on cfg_we:
  - Legal when 1 <= cfg_len <= MAX_LEN. Latch pattern, len and overlap; clear hist, fill and dout.
  - Illegal otherwise: keep the old config; set cfg_err (cleared only by reset).
  - cfg_we has priority: a din_vld bit in the same cycle is dropped.
- Shift, on din_vld with no cfg_we:
  - hist <= {hist[MAX_LEN-2:0], din}
  - fill <= min(fill+1, MAX_LEN)
- Match condition, evaluated on the next-state values:
  - len != 0, fill_next >= len, and hist_next[len-1:0] == pattern[len-1:0]
  - Comparison is masked by len; bits above len-1 are ignored.
- Output:
  - dout is registered. It is high for exactly the one cycle following the edge that consumed the completing bit, then returns to 0.
  - Latency is 1 clk from bit acceptance to dout.
  - Cycles with din_vld low leave hist and fill unchanged and force dout to 0.
- Overlap mode 1: hist and fill are retained after a match. Example: 1101 on stream 1101101 matches at bits 4 and 7.
- Overlap mode 0: on a match, fill_next is forced to 0, so later matches need len fresh bits.
- Boundaries:
  - fill saturates at MAX_LEN; it never wraps.
  - len = MAX_LEN uses the full hist.
  - len = 1 can match on every valid bit.
- Reset mid-stream discards partial history; the bits after reset start from fill = 0.
- Internal state is the history register plus fill counter. An explicit FSM is used for disarmed/filling/armed:
  - DISARMED (len == 0) -> FILLING on a legal cfg write
  - FILLING -> ARMED when fill >= len
  - ARMED -> FILLING on a non-overlap match or a cfg write

Optional Feature:
SEQDET_CNT_EN
- Defined: match_cnt increments on every dout assertion and saturates at 2^CNT_W-1. It is cleared by reset and by a legal cfg write.
- Undefined: match_cnt is absent from the port list and no counter logic is built.

Decomposition:
- Package seqdet_pkg holds:
  - state encoding typedef (DISARMED, FILLING, ARMED)
  - MAX_LEN upper bound constant (32)
  - mode constants OVL_ON / OVL_OFF
- One natural sub-module, seqdet_hist: shift register, fill counter and masked comparator, producing a combinational match_next.
- The top level holds the config registers, FSM, dout register and optional counter.

Test Plan:
- Overlap: pattern 4'b1101, len 4, overlap 1; stream 1,1,0,1,1,0,1 with din_vld = 1 -> dout high in the cycle after bits 4 and 7, and only then.
- Non-overlap: same stream with overlap 0 -> dout high only after bit 4; bits 5-7 give fill = 3 and no match.
- Gaps and reset: stream 1,1,0 then rst_n low for 2 cycles, then 1 -> no dout. Separately, din_vld gaps mid-pattern (1,_,1,0,_,1) -> single match after the last bit.
- Config: cfg_we with cfg_len = 0 -> cfg_err = 1, old config kept. cfg_we in the same cycle as din_vld = 1 -> that bit ignored and fill = 0 afterwards.
- Lengths: len = 1, pattern 1, stream 1,0,1,1 -> dout after bits 1, 3 and 4. len = MAX_LEN = 8, pattern 8'hA5 -> match only after the 8th correct bit.
- Counter (SEQDET_CNT_EN, CNT_W = 2): 5 matches in overlap mode -> match_cnt = 1,2,3,3,3. A legal cfg write -> match_cnt = 0.
